symbol_decoder: RTL
===================

// Module: symbol_decoder
// PURPOSE
// - Receive-side inverse of the orientation symbol encoder. It tracks the previous 3-bit orientation
//   symbol (+x,-x,+y,-y,+z,-z) and recovers the {flip,rotate,polarity} (FRP) triple that produced
//   each new symbol.
// - Sits after the symbol sampler on the link and feeds recovered FRP bits to the payload deserializer.
// PARAMETERS
// - RESET_SYM  3'b000  symbol loaded as "previous" on reset/sync (+x; matches encoder reset state)
// - CNT_W      8       error counter width (used only with SYMDEC_ERRCNT_EN)
// PORTS
// - clk        in   1      clock, rising edge
// - rst        in   1      reset, asynchronous, active-high
// - sync_i     in   1      synchronous resync: prev <= RESET_SYM, FSM -> DECODE
// - sym_valid  in   1      sym_i is valid this cycle
// - sym_i      in   3      received symbol: 000 +x, 001 -x, 010 +y, 011 -y, 100 +z, 101 -z
// - frp_valid  out  1      one-cycle pulse: flip/rotate/polarity hold a decoded triple
// - flip       out  1      recovered F
// - rotate     out  1      recovered R
// - polarity   out  1      recovered P
// - rsvd_o     out  1      pulse: +x -> +x seen (encoder was driven with a reserved FRP code)
// - err_code   out  1      pulse: sym_i in {110,111}
// - err_seq    out  1      pulse: cur == prev, prev != +x (no legal encoder transition)
// - err_cnt    out  CNT_W  saturating error count (present only with SYMDEC_ERRCNT_EN)
// BEHAVIOUR
// - Reset: prev = RESET_SYM, state = DECODE, all outputs 0.
// - Latency: all outputs registered, asserted exactly 1 cycle after an accepted sym_valid.
// - Default: every pulse output is 0 on cycles with no accepted symbol. flip/rotate/polarity
//   hold their last decoded value.
// - Decode rule: prev = axis A, sign S; cur != prev; both codes legal:
//   - cur = prev axis (x<-y<-z<-x), same sign S      -> FRP 000
//   - cur = prev axis, sign !S                        -> FRP 001
//   - cur = next axis (x->y->z->x), same sign S       -> FRP 010
//   - cur = next axis, sign !S                        -> FRP 011
//   - cur = axis A, sign !S                           -> FRP 100
//   - These five destinations are distinct, so every cur != prev pair decodes uniquely.
// - FSM states: DECODE, RESYNC.
//   - DECODE, legal cur != prev: assert frp_valid, drive FRP, set prev <= cur.
//   - DECODE, cur == prev == +x: assert rsvd_o, no frp_valid, prev unchanged, stay in DECODE.
//   - DECODE, cur == prev != +x: assert err_seq, no frp_valid, prev unchanged, stay in DECODE.
//   - DECODE, sym_i in {110,111}: assert err_code, prev unchanged, go to RESYNC.
//   - RESYNC, legal symbol: prev <= sym_i, no output pulse, go to DECODE.
//   - RESYNC, illegal code: assert err_code again, stay in RESYNC.
// - sync_i together with sym_valid: sync wins and the symbol is dropped with no pulse.
// - sync_i in RESYNC: go to DECODE with prev = RESET_SYM.
// - rst mid-stream: immediate return to reset values. Any pending pulse is lost.
// CONFIGURATION
// - SYMDEC_ERRCNT_EN defined:
//   - err_cnt port exists; reset value 0.
//   - Increments by 1 on each err_code or err_seq pulse (not on rsvd_o).
//   - Saturates at 2^CNT_W-1 and does not wrap.
//   - Cleared by sync_i.
// - SYMDEC_ERRCNT_EN undefined: err_cnt port and counter logic are absent. All other behaviour is identical.
// STRUCTURE
// - symbol_pkg holds:
//   - symbol codes POS_X..NEG_Z
//   - sym_t (3-bit) and frp_t (3-bit {F,R,P})
//   - the DECODE/RESYNC state enum
//   - functions axis_of, sign_of, next_axis, prev_axis
//   - The encoder is also updated to import symbol_pkg.
// - Sub-module symbol_xition_lut: combinational (prev, cur) -> {frp, legal, same, bad_code}.
//   The top level contains the FSM, prev register, output registers and optional counter.
// TESTING
// - Reset, then +y(010) -> FRP 010 the next cycle; then -y(011) -> FRP 100;
//   then -x(001) -> 000; then +z(100) -> 001.
// - Drive the encoder with all 5 legal FRPs from each of the 6 states into the decoder:
//   recovered FRP == stimulus for all 30 cases.
// - From +x send +x -> rsvd_o=1, frp_valid=0. From +y send +y -> err_seq=1, prev stays +y.
// - Send 110 -> err_code. Then 111 -> err_code. Then -z -> no pulse (RESYNC load).
//   Then +z -> FRP 100.
// - sync_i and sym_valid=+y in the same cycle -> no output.
//   Next +y -> FRP 010 (prev was +x).
// - With SYMDEC_ERRCNT_EN and CNT_W=2: five errors -> err_cnt saturates at 3. sync_i -> 0.

Source files
------------

// File: rtl/symbol_pkg.sv
// ============================================================================
// Package     : symbol_pkg
// Description : Shared types, symbol codes, FSM state enum and axis helpers
//               for the orientation symbol encoder/decoder pair.
//               A symbol is {axis[1:0], sign}: axis 0=x, 1=y, 2=z, and
//               sign 1 means negative. Axis code 3 is never legal.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package symbol_pkg;

  typedef logic [2:0] sym_t;
  typedef logic [2:0] frp_t;   // {flip, rotate, polarity}

  localparam sym_t POS_X = 3'b000;
  localparam sym_t NEG_X = 3'b001;
  localparam sym_t POS_Y = 3'b010;
  localparam sym_t NEG_Y = 3'b011;
  localparam sym_t POS_Z = 3'b100;
  localparam sym_t NEG_Z = 3'b101;

  localparam logic [1:0] AXIS_X = 2'd0;
  localparam logic [1:0] AXIS_Y = 2'd1;
  localparam logic [1:0] AXIS_Z = 2'd2;

  typedef enum logic [0:0] {
    ST_DECODE = 1'b0,
    ST_RESYNC = 1'b1
  } dec_state_t;

  function automatic logic [1:0] axis_of(input sym_t s);
    return s[2:1];
  endfunction

  function automatic logic sign_of(input sym_t s);
    return s[0];
  endfunction

  // x -> y -> z -> x
  function automatic logic [1:0] next_axis(input logic [1:0] a);
    case (a)
      AXIS_X:  return AXIS_Y;
      AXIS_Y:  return AXIS_Z;
      default: return AXIS_X;
    endcase
  endfunction

  // x <- y <- z <- x
  function automatic logic [1:0] prev_axis(input logic [1:0] a);
    case (a)
      AXIS_X:  return AXIS_Z;
      AXIS_Y:  return AXIS_X;
      default: return AXIS_Y;
    endcase
  endfunction

  function automatic logic is_legal(input sym_t s);
    return s[2:1] != 2'b11;
  endfunction

endpackage

`default_nettype wire

// File: rtl/symbol_xition_lut.sv
// ============================================================================
// Module      : symbol_xition_lut
// Description : Combinational map from a (previous, current) symbol pair to
//               the FRP triple the encoder must have applied.
// Ports       : prev_i     [2:0] in  - previous (accepted) symbol
//               cur_i      [2:0] in  - newly received symbol
//               frp_o      [2:0] out - decoded {F,R,P}; 0 when not legal_o
//               legal_o          out - cur is a decodable transition
//               same_o           out - cur equals prev
//               bad_code_o       out - cur is an illegal code (110/111)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module symbol_xition_lut
  import symbol_pkg::*;
(
  input  logic [2:0] prev_i,
  input  logic [2:0] cur_i,
  output logic [2:0] frp_o,
  output logic       legal_o,
  output logic       same_o,
  output logic       bad_code_o
);

  logic [1:0] w_prev_axis;
  logic [1:0] w_cur_axis;
  logic       w_sign_flip;

  assign w_prev_axis = axis_of(prev_i);
  assign w_cur_axis  = axis_of(cur_i);
  assign w_sign_flip = sign_of(cur_i) ^ sign_of(prev_i);

  assign bad_code_o = !is_legal(cur_i);
  assign same_o     = (cur_i == prev_i);
  assign legal_o    = !bad_code_o && !same_o;

  // Once cur != prev is known, the axis relation alone picks F/R and the
  // sign change gives P; a same-axis move must be a pure sign flip (F=1).
  always_comb begin
    frp_o = 3'b000;
    if (legal_o) begin
      if (w_cur_axis == prev_axis(w_prev_axis)) begin
        frp_o = {2'b00, w_sign_flip};
      end else if (w_cur_axis == next_axis(w_prev_axis)) begin
        frp_o = {2'b01, w_sign_flip};
      end else begin
        frp_o = 3'b100;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/symbol_decoder.sv
// ============================================================================
// Module      : symbol_decoder
// Description : Recovers the {flip,rotate,polarity} triple from consecutive
//               orientation symbols. Tracks the previous symbol, flags the
//               reserved +x->+x case, repeated symbols and illegal codes, and
//               re-acquires the stream after an illegal code (RESYNC).
// Parameters  : RESET_SYM - symbol loaded as "previous" on reset / sync_i
//               CNT_W     - error counter width (SYMDEC_ERRCNT_EN only)
// Ports       : clk, rst (async, active-high)
//               sync_i          in  - resync: prev <= RESET_SYM, go DECODE
//               sym_valid       in  - sym_i valid this cycle
//               sym_i     [2:0] in  - received symbol
//               frp_valid       out - pulse, FRP outputs hold a new triple
//               flip/rotate/polarity out - last decoded triple (held)
//               rsvd_o          out - pulse, +x followed by +x
//               err_code        out - pulse, illegal code received
//               err_seq         out - pulse, repeated symbol other than +x
//               err_cnt         out - saturating error count (macro only)
// Config      : `define SYMDEC_ERRCNT_EN adds CNT_W and the err_cnt port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module symbol_decoder
  import symbol_pkg::*;
#(
  parameter logic [2:0] RESET_SYM = 3'b000
`ifdef SYMDEC_ERRCNT_EN
  ,
  parameter int         CNT_W     = 8
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sync_i,
  input  logic             sym_valid,
  input  logic [2:0]       sym_i,
  output logic             frp_valid,
  output logic             flip,
  output logic             rotate,
  output logic             polarity,
  output logic             rsvd_o,
  output logic             err_code,
  output logic             err_seq
`ifdef SYMDEC_ERRCNT_EN
  ,
  output logic [CNT_W-1:0] err_cnt
`endif
);

  dec_state_t state_q, state_d;
  logic [2:0] prev_q, prev_d;
  logic [2:0] frp_q, frp_d;
  logic       frp_valid_q, frp_valid_d;
  logic       rsvd_q, rsvd_d;
  logic       err_code_q, err_code_d;
  logic       err_seq_q, err_seq_d;

  logic [2:0] w_lut_frp;
  logic       w_legal;
  logic       w_same;
  logic       w_bad_code;

  symbol_xition_lut u_lut (
    .prev_i     (prev_q),
    .cur_i      (sym_i),
    .frp_o      (w_lut_frp),
    .legal_o    (w_legal),
    .same_o     (w_same),
    .bad_code_o (w_bad_code)
  );

  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    frp_d       = frp_q;
    frp_valid_d = 1'b0;
    rsvd_d      = 1'b0;
    err_code_d  = 1'b0;
    err_seq_d   = 1'b0;

    // sync_i takes priority over any symbol arriving in the same cycle.
    if (sync_i) begin
      state_d = ST_DECODE;
      prev_d  = RESET_SYM;
    end else if (sym_valid) begin
      case (state_q)
        ST_DECODE: begin
          if (w_bad_code) begin
            err_code_d = 1'b1;
            state_d    = ST_RESYNC;
          end else if (w_legal) begin
            frp_valid_d = 1'b1;
            frp_d       = w_lut_frp;
            prev_d      = sym_i;
          end else if (w_same) begin
            // +x->+x is what the encoder emits for a reserved FRP code.
            if (prev_q == POS_X) begin
              rsvd_d = 1'b1;
            end else begin
              err_seq_d = 1'b1;
            end
          end
        end
        ST_RESYNC: begin
          if (w_bad_code) begin
            err_code_d = 1'b1;
          end else begin
            // First good symbol only re-seeds the reference, no decode.
            prev_d  = sym_i;
            state_d = ST_DECODE;
          end
        end
        default: begin
          state_d = ST_DECODE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_DECODE;
      prev_q      <= RESET_SYM;
      frp_q       <= 3'b000;
      frp_valid_q <= 1'b0;
      rsvd_q      <= 1'b0;
      err_code_q  <= 1'b0;
      err_seq_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      frp_q       <= frp_d;
      frp_valid_q <= frp_valid_d;
      rsvd_q      <= rsvd_d;
      err_code_q  <= err_code_d;
      err_seq_q   <= err_seq_d;
    end
  end

  assign frp_valid = frp_valid_q;
  assign flip      = frp_q[2];
  assign rotate    = frp_q[1];
  assign polarity  = frp_q[0];
  assign rsvd_o    = rsvd_q;
  assign err_code  = err_code_q;
  assign err_seq   = err_seq_q;

`ifdef SYMDEC_ERRCNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counts in the same edge that registers the error pulse, so err_cnt
  // already includes an error while its pulse is visible.
  always_comb begin
    cnt_d = cnt_q;
    if (sync_i) begin
      cnt_d = '0;
    end else if ((err_code_d || err_seq_d) && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign err_cnt = cnt_q;
`endif

endmodule

`default_nettype wire
